// File: rtl/div_pkg.sv
// div_pkg: state encoding and default frame pattern shared by the
// fractional M/N divider and its ratio monitor.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        TRACK,
        LOCKED
    } state_e;

    localparam int DIV_E = 8;
    localparam int DIV_O = 9;
    localparam int NUM_E = 3;
    localparam int NUM_O = 7;

    localparam int FRAME_LEN = NUM_E * DIV_E + NUM_O * DIV_O;

endpackage

// File: rtl/div_edge_period.sv
// div_edge_period: rising-edge detect on the divided clock and a
// saturating period counter running in the source-clock domain.
module div_edge_period #(
    parameter int CW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          div_clk_i,
    input  logic          active_i,
    output logic          rise_o,
    output logic [CW-1:0] period_o,
    output logic          period_vld_o,
    output logic          timeout_o
);

    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);

    logic          div_clk_q;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] period_q, period_d;
    logic          vld_q, vld_d;

    assign rise_o = div_clk_i & ~div_clk_q;

    // A rise on the cycle the count would hit TIMEOUT wins over the stall
    assign timeout_o = active_i & ~rise_o & (pcnt_q == TO_M1);

    always_comb begin
        pcnt_d   = pcnt_q;
        period_d = period_q;
        vld_d    = 1'b0;
        if (rise_o) begin
            pcnt_d = CW'(1);
            if (active_i) begin
                period_d = pcnt_q;
                vld_d    = 1'b1;
            end
        end else if (active_i && pcnt_q != TO_MAX) begin
            pcnt_d = pcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_clk_q <= 1'b0;
            pcnt_q    <= '0;
            period_q  <= '0;
            vld_q     <= 1'b0;
        end else begin
            div_clk_q <= div_clk_i;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            vld_q     <= vld_d;
        end
    end

    assign period_o     = period_q;
    assign period_vld_o = vld_q;

endmodule

// File: rtl/div_ratio_monitor.sv
// div_ratio_monitor: checks the divided clock against the E/O period frame.
// Define DIV_MON_DUTY_CHECK_EN to also check the high time of each period.
module div_ratio_monitor #(
    parameter int DIV_E       = div_pkg::DIV_E,
    parameter int DIV_O       = div_pkg::DIV_O,
    parameter int NUM_E       = div_pkg::NUM_E,
    parameter int NUM_O       = div_pkg::NUM_O,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 32,
    parameter int CW          = 8
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          div_clk,
    output logic          edge_pulse,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          frame_start,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic          stall
);

    import div_pkg::*;

    localparam int NP = NUM_E + NUM_O;
    localparam int IW = $clog2(NP);
    localparam int LW = $clog2(LOCK_FRAMES + 1);

    localparam logic [IW-1:0] LAST   = IW'(NP - 1);
    localparam logic [IW-1:0] IDX_E  = IW'(NUM_E);
    localparam logic [LW-1:0] LOCK_N = LW'(LOCK_FRAMES);
    localparam logic [CW-1:0] PER_E  = CW'(DIV_E);
    localparam logic [CW-1:0] PER_O  = CW'(DIV_O);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] clean_q, clean_d;
    logic [CW-1:0] ecnt_q, ecnt_d;
    logic          prev_o_q, prev_o_d;
    logic          edge_q, edge_d;
    logic          fs_q, fs_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic          stall_q, stall_d;

    logic          rise, pvld, tmo, active, bad;
    logic [CW-1:0] per, exp_per;

    assign active = (state_q != IDLE);

    div_edge_period #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_edge (
        .clk_i        (clk_in),
        .rst_ni       (rst),
        .div_clk_i    (div_clk),
        .active_i     (active),
        .rise_o       (rise),
        .period_o     (per),
        .period_vld_o (pvld),
        .timeout_o    (tmo)
    );

    assign exp_per = (idx_q < IDX_E) ? PER_E : PER_O;

`ifdef DIV_MON_DUTY_CHECK_EN
    logic [CW-1:0] hcnt_q, hcnt_d, hi_q;

    always_comb begin
        hcnt_d = hcnt_q;
        if (rise) begin
            hcnt_d = CW'(1);
        end else if (div_clk && hcnt_q != '1) begin
            hcnt_d = hcnt_q + CW'(1);
        end
    end

    // hi_q holds the high time of the period reported with period_vld
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            hi_q   <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            if (rise) begin
                hi_q <= hcnt_q;
            end
        end
    end

    assign bad = (per != exp_per)
               | ((hi_q != (exp_per >> 1))
               &  (hi_q != ((exp_per + CW'(1)) >> 1)));
`else
    assign bad = (per != exp_per);
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clean_d  = clean_q;
        ecnt_d   = ecnt_q;
        prev_o_d = prev_o_q;
        lock_d   = lock_q;
        stall_d  = stall_q;
        edge_d   = rise;
        fs_d     = 1'b0;
        err_d    = 1'b0;
        if (rise) begin
            stall_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                prev_o_d = 1'b0;
                if (rise) begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (pvld) begin
                    if (prev_o_q && per == PER_E) begin
                        fs_d    = 1'b1;
                        idx_d   = IW'(1);
                        state_d = TRACK;
                    end
                    prev_o_d = (per == PER_O);
                end
            end
            TRACK, LOCKED: begin
                if (pvld) begin
                    if (bad) begin
                        err_d    = 1'b1;
                        ecnt_d   = (ecnt_q == '1) ? ecnt_q
                                 : ecnt_q + CW'(1);
                        clean_d  = '0;
                        lock_d   = 1'b0;
                        prev_o_d = 1'b0;
                        state_d  = ALIGN;
                    end else if (idx_q == LAST) begin
                        idx_d   = '0;
                        fs_d    = 1'b1;
                        clean_d = (clean_q == LOCK_N) ? clean_q
                                : clean_q + LW'(1);
                        if (clean_d == LOCK_N) begin
                            lock_d  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            stall_d = 1'b1;
            lock_d  = 1'b0;
            clean_d = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            clean_q  <= '0;
            ecnt_q   <= '0;
            prev_o_q <= 1'b0;
            edge_q   <= 1'b0;
            fs_q     <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            clean_q  <= clean_d;
            ecnt_q   <= ecnt_d;
            prev_o_q <= prev_o_d;
            edge_q   <= edge_d;
            fs_q     <= fs_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    assign edge_pulse  = edge_q;
    assign period      = per;
    assign period_vld  = pvld;
    assign frame_start = fs_q;
    assign locked      = lock_q;
    assign err         = err_q;
    assign err_cnt     = ecnt_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_div_ratio_monitor.sv
// tb_div_ratio_monitor: scoreboard bench for div_ratio_monitor driven by
// a segment-level divided-clock generator and an event-level frame model.
module tb_div_ratio_monitor;

    localparam int DIV_E = 8;
    localparam int DIV_O = 9;
    localparam int NUM_E = 3;
    localparam int NUM_O = 7;
    localparam int NP = NUM_E + NUM_O;
    localparam int LOCK_FRAMES = 2;
    localparam int TIMEOUT = 32;
    localparam int CW = 8;
    localparam int ERR_MAX = 255;
`ifdef DIV_MON_DUTY_CHECK_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst;
    logic div_clk;
    logic edge_pulse, period_vld, frame_start, locked, err, stall;
    logic [CW-1:0] period, err_cnt;

    div_ratio_monitor dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .div_clk     (div_clk),
        .edge_pulse  (edge_pulse),
        .period      (period),
        .period_vld  (period_vld),
        .frame_start (frame_start),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .stall       (stall)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int kind;   // 0: period report, 1: stall
        int per;
        int err;
        int fs;
        int lock;
        int ecnt;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int pat[$];

    // model state: mode 0 idle, 1 aligning, 2 tracking
    int m_mode = 0, m_prev_o = 0, m_idx = 0;
    int m_clean = 0, m_lock = 0, m_ecnt = 0;
    int last_p = 0, last_h = 0;

    bit post = 0;
    bit prev_stall = 0;
    exp_t cur;

    task automatic chk(input string nm, input int act, input int ev);
        n_cmp++;
        if (act != ev) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, ev, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_edge_pulse"}, int'(edge_pulse), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_period_vld"}, int'(period_vld), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_stall"}, int'(stall), 0);
    endtask

    // Reference: what the monitor must report for one completed period g
    task automatic m_rise(input int g, input int hi);
        exp_t e;
        int ex;
        bit bad;
        bit duty_ok;
        if (m_mode == 0) begin
            m_mode = 1;
            m_prev_o = 0;
            return;
        end
        e = '{kind: 0, per: g, err: 0, fs: 0, lock: 0, ecnt: 0};
        if (m_mode == 1) begin
            if (m_prev_o != 0 && g == DIV_E) begin
                e.fs = 1;
                m_idx = 1;
                m_mode = 2;
            end
            m_prev_o = (g == DIV_O) ? 1 : 0;
        end else begin
            ex = pat[m_idx];
            duty_ok = (hi == ex / 2) || (hi == (ex + 1) / 2);
            bad = (g != ex) || (DUTY_EN && !duty_ok);
            if (bad) begin
                e.err = 1;
                if (m_ecnt < ERR_MAX) m_ecnt++;
                m_clean = 0;
                m_lock = 0;
                m_mode = 1;
                m_prev_o = 0;
            end else begin
                m_idx++;
                if (m_idx == NP) begin
                    m_idx = 0;
                    e.fs = 1;
                    if (m_clean < LOCK_FRAMES) m_clean++;
                    if (m_clean == LOCK_FRAMES) m_lock = 1;
                end
            end
        end
        e.lock = m_lock;
        e.ecnt = m_ecnt;
        q.push_back(e);
    endtask

    // One divided-clock period: high h cycles then low p-h cycles
    task automatic seg(input int p, input int h);
        exp_t e;
        m_rise(last_p, last_h);
        if (p >= TIMEOUT && m_mode != 0) begin
            e = '{kind: 1, per: 0, err: 0, fs: 0, lock: 0, ecnt: m_ecnt};
            q.push_back(e);
            m_mode = 0;
            m_lock = 0;
            m_clean = 0;
        end
        last_p = p;
        last_h = h;
        for (int i = 0; i < p; i++) begin
            div_clk = (i < h);
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic int hv(input int p);
        return ($urandom_range(0, 1) != 0) ? p / 2 : (p + 1) / 2;
    endfunction

    task automatic frame(input int pos, input int p, input int h);
        for (int i = 0; i < NP; i++) begin
            if (i == pos) seg(p, h);
            else seg(pat[i], hv(pat[i]));
        end
    endtask

    task automatic rand_frame();
        int p, h;
        for (int i = 0; i < NP; i++) begin
            p = pat[i];
            if ($urandom_range(0, 7) == 0) p = $urandom_range(3, 34);
            if ($urandom_range(0, 3) == 0) h = $urandom_range(1, p - 1);
            else h = hv(p);
            seg(p, h);
        end
    endtask

    // Monitor: pops expectations whenever the DUT reports
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                post = 0;
                prev_stall = 0;
            end else begin
                if (post) begin
                    chk("err", int'(err), cur.err);
                    chk("frame_start", int'(frame_start), cur.fs);
                    chk("locked", int'(locked), cur.lock);
                    chk("err_cnt", int'(err_cnt), cur.ecnt);
                    post = 0;
                end else begin
                    chk("no_spurious_err", int'(err), 0);
                    chk("no_spurious_fs", int'(frame_start), 0);
                end
                if (period_vld) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL vld_unexpected: period=%0d required none",
                                 period);
                    end else begin
                        cur = q.pop_front();
                        chk("vld_kind", 0, cur.kind);
                        chk("period", int'(period), cur.per);
                        chk("edge_with_vld", int'(edge_pulse), 1);
                        post = 1;
                    end
                end
                if (stall && !prev_stall) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL stall_unexpected: stall=1 required 0");
                    end else begin
                        cur = q.pop_front();
                        chk("stall_kind", 1, cur.kind);
                        chk("stall_locked", int'(locked), 0);
                    end
                end
                if (!stall && prev_stall) begin
                    chk("stall_clear_on_rise", int'(edge_pulse), 1);
                end
                prev_stall = stall;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        for (int i = 0; i < NUM_E; i++) pat.push_back(DIV_E);
        for (int i = 0; i < NUM_O; i++) pat.push_back(DIV_O);
        rst = 1'b0;
        div_clk = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst = 1'b1;

        // Clean divider output from reset
        repeat (5) frame(-1, 0, 0);
        chk("locked_5_frames", int'(locked), 1);
        chk("err_cnt_5_frames", int'(err_cnt), 0);

        // One stretched long period while locked
        frame(5, 10, 5);
        chk("stretch_err_cnt", int'(err_cnt), 1);
        chk("stretch_unlocked", int'(locked), 0);
        repeat (3) frame(-1, 0, 0);
        chk("relock", int'(locked), 1);

        // Stall: div_clk low for 40 cycles
        seg(44, 4);
        chk("stall_level", int'(stall), 1);
        chk("stall_locked", int'(locked), 0);
        repeat (3) frame(-1, 0, 0);
        chk("stall_cleared", int'(stall), 0);

        // TIMEOUT boundary: gap of 31 is a period, 32 is a stall
        seg(31, 4);
        seg(32, 4);
        chk("stall_at_timeout", int'(stall), 1);
        repeat (3) frame(-1, 0, 0);

`ifdef DIV_MON_DUTY_CHECK_EN
        e0 = m_ecnt;
        frame(4, 9, 6);
        chk("duty_err_cnt", int'(err_cnt), e0 + 1);
        repeat (3) frame(-1, 0, 0);
`endif

        // Reset in the middle of a frame while locked
        repeat (2) frame(-1, 0, 0);
        chk("locked_before_rst", int'(locked), m_lock);
        m_rise(last_p, last_h);
        last_p = 8;
        last_h = 4;
        for (int i = 0; i < 5; i++) begin
            div_clk = (i < 4);
            @(posedge clk_in);
            #1;
        end
        rst = 1'b0;
        div_clk = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(posedge clk_in);
        #1;
        q.delete();
        m_mode = 0;
        m_prev_o = 0;
        m_idx = 0;
        m_clean = 0;
        m_lock = 0;
        m_ecnt = 0;
        last_p = 0;
        last_h = 0;
        rst = 1'b1;
        repeat (5) frame(-1, 0, 0);
        chk("locked_after_rst", int'(locked), 1);
        chk("err_cnt_after_rst", int'(err_cnt), 0);

        // Randomized periods, duty and occasional stalls
        repeat (8) rand_frame();
        repeat (3) frame(-1, 0, 0);

        // Mismatch flood: realign then break, 300 times
        repeat (300) begin
            seg(9, 4);
            seg(8, 4);
            seg(10, 5);
        end
        seg(8, 4);
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0 && !post) break;
            @(negedge clk_in);
        end
        chk("scoreboard_drained", q.size(), 0);
        chk("err_cnt_saturated", int'(err_cnt), ERR_MAX);
        chk("err_cnt_model", int'(err_cnt), m_ecnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
